// File: rtl/somador_serial_pkg.sv
// Shared types and helpers for the bit-serial adder.
package somador_serial_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Bit counter width; a 2-bit operand still needs one counter bit.
    function automatic int cnt_width(input int n);
        return (n <= 32'sd2) ? 32'sd1 : $clog2(n);
    endfunction

endpackage

// File: rtl/somador_serial_if.sv
// Operand/result bundle of the serial adder; carries ovf when SOMADOR_SERIAL_OVF_EN is defined.
interface somador_serial_if #(parameter int N = 4);

    logic         start;
    logic [N-1:0] A;
    logic [N-1:0] B;
    logic         C_in;
    logic         busy;
    logic         done;
    logic [N-1:0] S;
    logic         C_out;
`ifdef SOMADOR_SERIAL_OVF_EN
    logic         ovf;

    modport master (output start, A, B, C_in, input busy, done, S, C_out, ovf);
    modport slave  (input start, A, B, C_in, output busy, done, S, C_out, ovf);
`else
    modport master (output start, A, B, C_in, input busy, done, S, C_out);
    modport slave  (input start, A, B, C_in, output busy, done, S, C_out);
`endif

endinterface

// File: rtl/somador_completo.sv
// One-bit full adder cell used by the serial adder datapath.
module somador_completo (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/somador_serial.sv
// Bit-serial N-bit adder, LSB first, one full-adder cell plus a carry flop.
// Optional signed overflow output enabled by SOMADOR_SERIAL_OVF_EN.
module somador_serial
    import somador_serial_pkg::*;
#(
    parameter int N = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    somador_serial_if.slave bus
);

    localparam int CW = cnt_width(N);

    state_t         state_r, state_s;
    logic [N-1:0]   a_sr_r, b_sr_r, s_sr_r;
    logic           carry_r;
    logic [CW-1:0]  cnt_r;
    logic           sum_bit_s, carry_s;
    logic           load_s, shift_s, finish_s, last_s;
    logic           busy_r, done_r, c_out_r;
    logic [N-1:0]   s_r;

    assign last_s = (cnt_r == CW'(N - 32'sd1));

    somador_completo u_fa (
        .a    (a_sr_r[0]),
        .b    (b_sr_r[0]),
        .cin  (carry_r),
        .s    (sum_bit_s),
        .cout (carry_s)
    );

    // Next-state decode and datapath strobes
    always_comb begin
        state_s  = state_r;
        load_s   = 1'b0;
        shift_s  = 1'b0;
        finish_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (bus.start) begin
                    load_s  = 1'b1;
                    state_s = SHIFT;
                end else begin
                    state_s = IDLE;
                end
            end
            SHIFT: begin
                shift_s = 1'b1;
                if (last_s) begin
                    state_s = DONE;
                end else begin
                    state_s = SHIFT;
                end
            end
            DONE: begin
                finish_s = 1'b1;
                state_s  = IDLE;
            end
            default: state_s = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Operand shift registers, carry flop and bit counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sr_r  <= '0;
            b_sr_r  <= '0;
            s_sr_r  <= '0;
            carry_r <= 1'b0;
            cnt_r   <= '0;
        end else if (load_s) begin
            a_sr_r  <= bus.A;
            b_sr_r  <= bus.B;
            carry_r <= bus.C_in;
            cnt_r   <= '0;
        end else if (shift_s) begin
            a_sr_r  <= a_sr_r >> 1;
            b_sr_r  <= b_sr_r >> 1;
            s_sr_r  <= {sum_bit_s, s_sr_r[N-1:1]};
            carry_r <= carry_s;
            // Counter parks at zero after the last bit so it never reaches N
            cnt_r   <= last_s ? '0 : cnt_r + CW'(1'b1);
        end
    end

    // Registered result, done pulse and busy flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            s_r     <= '0;
            c_out_r <= 1'b0;
        end else begin
            busy_r <= (state_s != IDLE);
            done_r <= finish_s;
            if (finish_s) begin
                s_r     <= s_sr_r;
                c_out_r <= carry_r;
            end
        end
    end

    assign bus.busy  = busy_r;
    assign bus.done  = done_r;
    assign bus.S     = s_r;
    assign bus.C_out = c_out_r;

`ifdef SOMADOR_SERIAL_OVF_EN
    logic c_msb_r, ovf_r;

    // Carry into the MSB is the carry flop value entering the last bit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            c_msb_r <= 1'b0;
            ovf_r   <= 1'b0;
        end else begin
            if (shift_s && last_s) begin
                c_msb_r <= carry_r;
            end
            if (finish_s) begin
                ovf_r <= c_msb_r ^ carry_r;
            end
        end
    end

    assign bus.ovf = ovf_r;
`endif

endmodule

// File: tb/tb_somador_serial.sv
// Self-checking bench for somador_serial (N=4 directed, N=8 random back-to-back).
module tb_somador_serial;

    logic clk = 1'b0;
    logic rst_n;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    somador_serial_if #(.N(4)) b4();
    somador_serial_if #(.N(8)) b8();

    somador_serial #(.N(4)) d4 (.clk(clk), .rst_n(rst_n), .bus(b4));
    somador_serial #(.N(8)) d8 (.clk(clk), .rst_n(rst_n), .bus(b8));

    // One N=4 operation; optionally pulses start with other operands mid-SHIFT.
    task automatic run4(input logic [3:0] a, input logic [3:0] b, input logic cin, input bit mid,
                        output logic [3:0] s, output logic c, output logic v,
                        output int lat, output int busy_n, output int done_n);
        s = 4'h0; c = 1'b0; v = 1'b0; lat = 0; busy_n = 0; done_n = 0;
        @(negedge clk);
        b4.start = 1'b1; b4.A = a; b4.B = b; b4.C_in = cin;
        @(posedge clk); #1;
        b4.start = 1'b0;
        b4.A = 4'($urandom); b4.B = 4'($urandom); b4.C_in = 1'($urandom);
        if (b4.busy) busy_n++;
        for (int i = 1; i <= 10; i++) begin
            @(posedge clk); #1;
            if (mid && i == 2) begin
                b4.start = 1'b1; b4.A = 4'h7; b4.B = 4'h7;
            end else begin
                b4.start = 1'b0;
            end
            if (b4.busy) busy_n++;
            if (b4.done) begin
                done_n++;
                if (lat == 0) begin
                    lat = i; s = b4.S; c = b4.C_out;
`ifdef SOMADOR_SERIAL_OVF_EN
                    v = b4.ovf;
`endif
                end
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        b4.start = 1'b0; b4.A = 4'h0; b4.B = 4'h0; b4.C_in = 1'b0;
        b8.start = 1'b0; b8.A = 8'h0; b8.B = 8'h0; b8.C_in = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if ({b4.busy, b4.done, b4.S, b4.C_out} !== 7'h00) begin
            bad++; $display("FAIL reset4: got %b want 0", {b4.busy, b4.done, b4.S, b4.C_out});
        end
        total++;
        if ({b8.busy, b8.done, b8.S, b8.C_out} !== 11'h000) begin
            bad++; $display("FAIL reset8: got %b want 0", {b8.busy, b8.done, b8.S, b8.C_out});
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        logic [3:0] s; logic c, v; int lat, bn, dn;
        run4(4'h5, 4'h3, 1'b0, 1'b0, s, c, v, lat, bn, dn);
        total++; if (lat !== 5) begin bad++; $display("FAIL basic_latency: got %0d want 5", lat); end
        total++; if (bn !== 5) begin bad++; $display("FAIL basic_busy_cycles: got %0d want 5", bn); end
        total++; if (dn !== 1) begin bad++; $display("FAIL basic_done_count: got %0d want 1", dn); end
        total++; if ({c, s} !== 5'h08) begin bad++; $display("FAIL basic_sum: got %h want 08", {c, s}); end
    endtask

    task automatic test_carry();
        logic [3:0] s; logic c, v; int lat, bn, dn;
        run4(4'hF, 4'h1, 1'b0, 1'b0, s, c, v, lat, bn, dn);
        total++; if ({c, s} !== 5'h10) begin bad++; $display("FAIL carry_f1: got %h want 10", {c, s}); end
        run4(4'hF, 4'hF, 1'b1, 1'b0, s, c, v, lat, bn, dn);
        total++; if ({c, s} !== 5'h1F) begin bad++; $display("FAIL carry_ff1: got %h want 1f", {c, s}); end
    endtask

    task automatic test_start_ignored();
        logic [3:0] s; logic c, v; int lat, bn, dn;
        run4(4'h2, 4'h2, 1'b0, 1'b1, s, c, v, lat, bn, dn);
        total++; if ({c, s} !== 5'h04) begin bad++; $display("FAIL ignore_sum: got %h want 04", {c, s}); end
        total++; if (dn !== 1) begin bad++; $display("FAIL ignore_done_count: got %0d want 1", dn); end
    endtask

    task automatic test_abort();
        logic [3:0] s; logic c, v; int lat, bn, dn, spurious;
        run4(4'hF, 4'hF, 1'b1, 1'b0, s, c, v, lat, bn, dn);
        @(negedge clk);
        b4.start = 1'b1; b4.A = 4'h6; b4.B = 4'h5; b4.C_in = 1'b1;
        @(posedge clk); #1;
        b4.start = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        total++;
        if ({b4.busy, b4.done, b4.S, b4.C_out} !== 7'h00) begin
            bad++; $display("FAIL abort_outputs: got %b want 0", {b4.busy, b4.done, b4.S, b4.C_out});
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        spurious = 0;
        repeat (8) begin
            @(posedge clk); #1;
            if (b4.done) spurious++;
        end
        total++; if (spurious !== 0) begin bad++; $display("FAIL abort_no_done: got %0d want 0", spurious); end
        run4(4'h9, 4'h4, 1'b0, 1'b0, s, c, v, lat, bn, dn);
        total++; if ({c, s} !== 5'h0D) begin bad++; $display("FAIL abort_recover: got %h want 0d", {c, s}); end
    endtask

`ifdef SOMADOR_SERIAL_OVF_EN
    task automatic test_ovf();
        logic [3:0] s; logic c, v; int lat, bn, dn;
        run4(4'h7, 4'h1, 1'b0, 1'b0, s, c, v, lat, bn, dn);
        total++; if ({v, c, s} !== 6'h28) begin bad++; $display("FAIL ovf_71: got %h want 28", {v, c, s}); end
        run4(4'hF, 4'h1, 1'b0, 1'b0, s, c, v, lat, bn, dn);
        total++; if ({v, c, s} !== 6'h10) begin bad++; $display("FAIL ovf_f1: got %h want 10", {v, c, s}); end
    endtask
`endif

    task automatic test_random4();
        logic [3:0] s, a, b; logic c, v, cin; int lat, bn, dn;
        logic [4:0] want;
        for (int k = 0; k < 12; k++) begin
            a = 4'($urandom); b = 4'($urandom); cin = 1'($urandom);
            want = {1'b0, a} + {1'b0, b} + {4'h0, cin};
            run4(a, b, cin, 1'b0, s, c, v, lat, bn, dn);
            total++;
            if ({c, s} !== want || lat !== 5) begin
                bad++; $display("FAIL rand4: got %h lat %0d want %h lat 5", {c, s}, lat, want);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [8:0] exp_q[$];
        logic       exp_v_q[$];
        logic [8:0] want, sum;
        logic       want_v, c7;
        int         dn;
        dn = 0;
        @(negedge clk);
        b8.start = 1'b1;
        b8.A = 8'($urandom); b8.B = 8'($urandom); b8.C_in = 1'($urandom);
        for (int cyc = 0; cyc < 10000; cyc++) begin
            @(posedge clk);
            if (cyc % 10 == 0) begin
                sum = {1'b0, b8.A} + {1'b0, b8.B} + {8'h00, b8.C_in};
                c7  = 1'((({1'b0, b8.A[6:0]} + {1'b0, b8.B[6:0]} + {7'h00, b8.C_in}) >> 7));
                exp_q.push_back(sum);
                exp_v_q.push_back(c7 ^ sum[8]);
            end
            #1;
            if (b8.done) dn++;
            if (cyc % 10 == 9) begin
                want = exp_q.pop_front();
                want_v = exp_v_q.pop_front();
                total++;
                if (!b8.done) begin
                    bad++; $display("FAIL b2b_spacing: cycle %0d done=0 want 1", cyc);
                end else begin
                    total++;
                    if ({b8.C_out, b8.S} !== want) begin
                        bad++; $display("FAIL b2b_sum: cycle %0d got %h want %h", cyc, {b8.C_out, b8.S}, want);
                    end
`ifdef SOMADOR_SERIAL_OVF_EN
                    total++;
                    if (b8.ovf !== want_v) begin
                        bad++; $display("FAIL b2b_ovf: cycle %0d got %b want %b", cyc, b8.ovf, want_v);
                    end
`endif
                end
            end else if (b8.done) begin
                total++; bad++;
                $display("FAIL b2b_extra_done: cycle %0d done=1 want 0", cyc);
            end
            b8.A = 8'($urandom); b8.B = 8'($urandom); b8.C_in = 1'($urandom);
        end
        b8.start = 1'b0;
        total++; if (dn !== 1000) begin bad++; $display("FAIL b2b_done_total: got %0d want 1000", dn); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_carry();
        test_start_ignored();
        test_abort();
`ifdef SOMADOR_SERIAL_OVF_EN
        test_ovf();
`endif
        test_random4();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
